// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, defaults and sizing helper for the synchronous FIFO
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  typedef enum logic [1:0] {IDLE = 2'b00, WR = 2'b01, RD = 2'b10, WR_RD = 2'b11} fifo_op_e;
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W storage with one synchronous write port and one registered read port
module fifo_mem import fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] ra_i,
  output logic [DATA_W-1:0] rd_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  // storage array is deliberately left unreset
  always_ff @(posedge clk)
    if (we_i) mem_q[wa_i] <= wd_i;
  // read register loads only on an accepted read, so it holds otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_q <= '0;
    else if (re_i) rd_q <= mem_q[ra_i];
  assign rd_o = rd_q;
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised synchronous FIFO with thresholds, flush and sticky errors
module fifo_sync_param import fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_n,
  input  logic                          rd_n,
  input  logic                          flush,
  input  logic                          err_clr,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             data_out,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          over_flow,
  output logic                          under_flow,
  output logic                          ovf_sticky,
  output logic                          unf_sticky
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = fifo_cnt_w(DEPTH);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, ovf_st_q, ovf_st_d, unf_st_q, unf_st_d;
  logic              wr_acc, rd_acc;
  fifo_op_e          op;
  assign full         = count_q == CNT_W'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CNT_W'(AF_LVL);
  assign almost_empty = count_q <= CNT_W'(AE_LVL);
  // a pending read frees a slot, so a write is accepted when full if a read accompanies it
  always_comb begin
    wr_acc   = !flush && !wr_n && (!full || !rd_n);
    rd_acc   = !flush && !rd_n && !empty;
    op       = fifo_op_e'({rd_acc, wr_acc});
    wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(rd_acc);
    count_d  = flush ? '0 : (op == WR) ? count_q + 1'b1 : (op == RD) ? count_q - 1'b1 : count_q;
    ovf_d    = !flush && !wr_n && full && rd_n;
    unf_d    = !flush && !rd_n && empty;
    ovf_st_d = !err_clr && (ovf_st_q || ovf_d);
    unf_st_d = !err_clr && (unf_st_q || unf_d);
  end
  // control state; reset discards contents immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ovf_st_q <= 1'b0;
      unf_st_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ovf_st_q <= ovf_st_d;
      unf_st_q <= unf_st_d;
    end
  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (wr_acc),
    .wa_i  (wr_ptr_q),
    .wd_i  (data_in),
    .re_i  (rd_acc),
    .ra_i  (rd_ptr_q),
    .rd_o  (data_out)
  );
  assign count      = count_q;
  assign over_flow  = ovf_q;
  assign under_flow = unf_q;
  assign ovf_sticky = ovf_st_q;
  assign unf_sticky = unf_st_q;
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO; the next generation of the team's 8-bit, 16-deep FIFO with active-low strobes. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, defined simultaneous read/write behaviour, a synchronous flush, and sticky error flags. It sits between a producer and a consumer in the same clock domain and is driven by the same active-low `rd_n`/`wr_n` strobe style.

## Interface
- `DATA_W`, 8: data width in bits.
- `DEPTH`, 16: number of entries; power of two, at least 2.
- `AF_LVL`, DEPTH-2: `almost_full` asserts when count >= AF_LVL.
- `AE_LVL`, 2: `almost_empty` asserts when count <= AE_LVL.
- Derived: `ADDR_W` = $clog2(DEPTH); `CNT_W` = $clog2(DEPTH+1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_n`  in  1  write strobe, active low.
- `rd_n`  in  1  read strobe, active low.
- `flush`  in  1  synchronous clear of contents, active high.
- `err_clr`  in  1  clears the sticky error flags, active high.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  registered read data.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1  each  status flags.
- `over_flow`  out  1  one-cycle pulse when a write is rejected.
- `under_flow`  out  1  one-cycle pulse when a read is rejected.
- `ovf_sticky`, `unf_sticky`  out  1  each  latched error flags.

## Operation
- Write accepted: `!wr_n && (!full || !rd_n)`. The word is stored at `wr_ptr`, and `wr_ptr` increments.
- Read accepted: `!rd_n && !empty`. `data_out` loads `mem[rd_ptr]`, and `rd_ptr` increments.
- `count` next value = count + wr_acc - rd_acc.
- Pointers are ADDR_W bits wide and wrap from DEPTH-1 to 0 with no extra logic.
- Flags decode combinationally from the `count` register:
  - `full` = (count == DEPTH)
  - `empty` = (count == 0)
  - `almost_full` and `almost_empty` follow the threshold rules above.
- Full with both strobes: the read and the write are both accepted, count is unchanged, and there is no `over_flow`.
- Empty with both strobes: the write is accepted, the read is rejected, `under_flow` pulses, `data_out` holds, and count becomes 1.
- Rejected write (`!wr_n`, full, `rd_n` high): memory, pointers and count are unchanged; `over_flow` = 1 for one cycle.
- Rejected read (`!rd_n`, empty): `data_out` is unchanged; `under_flow` = 1 for one cycle.
- Sticky flags:
  - `ovf_sticky` / `unf_sticky` set on their pulse and hold until `err_clr`.
  - `err_clr` has priority over a new set in the same cycle.
- `flush`:
  - Overrides `rd_n`/`wr_n` in the same cycle.
  - Pointers and count go to 0; `data_out` holds.
  - No error pulses; sticky flags are unaffected.
- Reset values: pointers 0, count 0, `data_out` 0, `empty` 1, `almost_empty` 1, `full` 0, `almost_full` 0, all error outputs 0.
  - Memory contents are not reset.
  - Asserting reset mid-operation discards all contents immediately.

## Timing
- Write-to-visibility: a word written at edge N is readable by a read accepted at edge N+1 or later. There is no same-cycle bypass when empty.
- Read latency: `data_out` is valid immediately after the edge that accepts the read, and holds until the next accepted read.
- `count` and all flags update on the same edge as the accepted operation.
- `over_flow` / `under_flow` are registered: high for exactly the cycle after the offending edge.
- Reset is asserted asynchronously. Deassertion is assumed synchronised upstream; the first operation is allowed on the first rising edge after `rst_n` goes high.

## Structure
- Package `fifo_pkg`:
  - `fifo_op_e` enum (IDLE, WR, RD, WR_RD).
  - A `fifo_cnt_w(depth)` function.
  - Shared default constants for DATA_W and DEPTH.
- Sub-module `fifo_mem`: DEPTH x DATA_W register array with one synchronous write port and one synchronous read port. No reset.
- Control logic (pointers, count, flags, errors) lives in the top module.

## Test plan
- Reset with DEPTH=16, then write 16..1: `count` = 16, `full` = 1, `almost_full` asserted at count 14, no `over_flow`.
- Two further writes while full: `over_flow` pulses twice, `ovf_sticky` = 1, count stays 16. Then 16 reads return 16..1 in order; `empty` = 1 after the last read.
- Two reads while empty: `under_flow` pulses twice, `data_out` holds 1, `unf_sticky` = 1. Then pulse `err_clr`: both sticky flags return to 0.
- Simultaneous read and write, both when full and when empty:
  - Full: count stays 16 and the oldest word is returned.
  - Empty: count goes 0 -> 1, `under_flow` = 1.
- Wrap-around: 40 interleaved write/read pairs of 0x00..0x27 with DATA_W=12, DEPTH=8. Output matches a scoreboard and the pointers wrap 5 times.
- `flush` at count 5 with `wr_n` low: count = 0, `empty` = 1, write ignored, `data_out` holds. Also assert `rst_n` mid-burst: all outputs return to their reset values asynchronously.
